unified_mem_arbiter: RTL and testbench



---
 rtl/unified_mem_arbiter_pkg.sv | 25 ++
 rtl/unified_mem_arbiter_if.sv | 48 ++++
 rtl/mem_arb_pick.sv | 18 +
 rtl/unified_mem_arbiter.sv | 96 +++++++++
 tb/tb_unified_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared codes for the unified instruction/data memory arbiter.
// Access sizes, owner tags, FSM states and counter sizing helper.
package unified_mem_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int STREAK_W = 4;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic int cnt_width(input int rd_lat);
        return (rd_lat > 1) ? $clog2(rd_lat) : 1;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, load/store and memory-side signals of the unified arbiter.
// master = requesters plus memory model, slave = arbiter.
interface unified_mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata;
    logic        busy;

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_size,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_size,
        input  busy
    );

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_size,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_size,
        output busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selector for one issue slot.
// Data wins by default; fetch wins when the data streak hits its cap.
module mem_arb_pick (
    input  logic if_req,
    input  logic d_req,
    input  logic streak_max,
    input  logic slot_free,
    output logic if_gnt,
    output logic d_gnt
);

    logic force_if;

    assign force_if = if_req & streak_max;
    assign d_gnt    = slot_free & d_req & ~force_if;
    assign if_gnt   = slot_free & if_req & (~d_req | force_if);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-ported memory arbiter between fetch and load/store.
// Tracks one outstanding read for RD_LAT cycles and routes rvalid.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    unified_mem_arbiter_if.slave  bus
);

    localparam int CW = cnt_width(RD_LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);
    localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(MAX_STREAK);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic slot_free;
    logic ret_cycle;
    logic if_gnt;
    logic d_gnt;
    logic rd_gnt;

    // The return cycle doubles as a free slot so reads issue back-to-back.
    always_comb begin
        slot_free = ~rst & ((state_q == ST_IDLE) | (cnt_q == '0));
        ret_cycle = ~rst & (state_q == ST_WAIT) & (cnt_q == '0);
    end

    mem_arb_pick u_pick (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .streak_max (streak_q == STREAK_CAP),
        .slot_free  (slot_free),
        .if_gnt     (if_gnt),
        .d_gnt      (d_gnt)
    );

    assign rd_gnt = if_gnt | (d_gnt & ~bus.d_we);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        if (state_q == ST_WAIT && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else if (rd_gnt) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
            owner_d = if_gnt ? OWN_IF : OWN_D;
        end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
        if (!bus.if_req || if_gnt) begin
            streak_d = '0;
        end else if (d_gnt && streak_q != '1) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            owner_q  <= OWN_IF;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_en    = if_gnt | d_gnt;
    assign bus.mem_we    = d_gnt & bus.d_we;
    assign bus.mem_addr  = d_gnt ? bus.d_addr : bus.if_addr;
    assign bus.mem_wdata = bus.d_wdata;
    assign bus.mem_size  = d_gnt ? bus.d_size : SZ_WORD;

    assign bus.if_rvalid = ret_cycle & (owner_q == OWN_IF);
    assign bus.d_rvalid  = ret_cycle & (owner_q == OWN_D);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.busy      = (state_q == ST_WAIT);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a read-return scoreboard.
// Behavioural memory with fixed read latency sits on the mem_* side.
module tb_unified_mem_arbiter;
    import unified_mem_arbiter_pkg::*;

    localparam int RD_LAT     = 2;
    localparam int MAX_STREAK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    unified_mem_arbiter_if bus ();

    unified_mem_arbiter #(
        .RD_LAT     (RD_LAT),
        .MAX_STREAK (MAX_STREAK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_pipe [RD_LAT];

    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_we)
            rd_pipe[0] <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
        else
            rd_pipe[0] <= 32'hDEAD_BEEF;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every rvalid must match the oldest outstanding expected read.
    always @(negedge clk) begin
        if (bus.if_rvalid || bus.d_rvalid) begin
            if (bus.if_rvalid && bus.d_rvalid) begin
                chk("dual_rvalid", {30'b0, bus.if_rvalid, bus.d_rvalid}, 32'h1);
            end else if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rvalid: if_rvalid=%b d_rvalid=%b none expected at %0t",
                         bus.if_rvalid, bus.d_rvalid, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rvalid_owner", {31'b0, bus.d_rvalid}, {31'b0, mon_e.is_d});
                chk("rdata", mon_e.is_d ? bus.d_rdata : bus.if_rdata, mon_e.data);
            end
        end
    end

    task automatic drive_idle();
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        bus.d_size  = SZ_WORD;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_gnt(input string tag, input logic ig, input logic dg);
        chk({tag, "_if_gnt"}, {31'b0, bus.if_gnt}, {31'b0, ig});
        chk({tag, "_d_gnt"}, {31'b0, bus.d_gnt}, {31'b0, dg});
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) break;
        end
        chk("idle_timeout", {31'b0, bus.busy}, 32'h0);
    endtask

    initial begin
        mem[32'h10]  = 32'h0050_0093;
        mem[32'h14]  = 32'h00A0_0113;
        mem[32'h20]  = 32'h0000_0013;
        mem[32'h100] = 32'hCAFE_F00D;
        drive_idle();

        // Requests during reset must be ignored.
        rst = 1'b1;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h10;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h100;
        repeat (3) begin
            @(negedge clk);
            expect_gnt("rst", 1'b0, 1'b0);
            chk("rst_mem_en", {31'b0, bus.mem_en}, 32'h0);
            chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        end
        drive_edge();
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        chk("reset_busy", {31'b0, bus.busy}, 32'h0);
        chk("idle_mem_en", {31'b0, bus.mem_en}, 32'h0);

        // Single fetch, latency 2.
        drive_edge();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h10;
        @(negedge clk);
        expect_gnt("t1", 1'b1, 1'b0);
        chk("t1_mem_addr", bus.mem_addr, 32'h10);
        chk("t1_mem_size", {30'b0, bus.mem_size}, 32'h2);
        chk("t1_mem_we", {31'b0, bus.mem_we}, 32'h0);
        exp_q.push_back({1'b0, 32'h0050_0093});
        drive_edge();
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("t1_busy_c1", {31'b0, bus.busy}, 32'h1);
        @(negedge clk);
        chk("t1_busy_c2", {31'b0, bus.busy}, 32'h1);
        @(negedge clk);
        chk("t1_busy_c3", {31'b0, bus.busy}, 32'h0);

        // Simultaneous fetch and load: load first, fetch in its return cycle.
        drive_edge();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h20;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h100;
        bus.d_size = SZ_WORD;
        @(negedge clk);
        expect_gnt("t2_c0", 1'b0, 1'b1);
        chk("t2_mem_addr_d", bus.mem_addr, 32'h100);
        exp_q.push_back({1'b1, 32'hCAFE_F00D});
        drive_edge();
        bus.d_req = 1'b0;
        @(negedge clk);
        expect_gnt("t2_c1", 1'b0, 1'b0);
        @(negedge clk);
        expect_gnt("t2_c2", 1'b1, 1'b0);
        chk("t2_mem_addr_if", bus.mem_addr, 32'h20);
        exp_q.push_back({1'b0, 32'h0000_0013});
        drive_edge();
        bus.if_req = 1'b0;
        wait_idle();

        // Byte store, then a fetch of the stored location the next cycle.
        drive_edge();
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h203;
        bus.d_wdata = 32'hAB;
        bus.d_size = SZ_BYTE;
        @(negedge clk);
        expect_gnt("t3", 1'b0, 1'b1);
        chk("t3_mem_en", {31'b0, bus.mem_en}, 32'h1);
        chk("t3_mem_we", {31'b0, bus.mem_we}, 32'h1);
        chk("t3_mem_size", {30'b0, bus.mem_size}, 32'h0);
        chk("t3_mem_addr", bus.mem_addr, 32'h203);
        chk("t3_mem_wdata", bus.mem_wdata, 32'hAB);
        drive_edge();
        drive_idle();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h203;
        @(negedge clk);
        chk("t3_busy_after_store", {31'b0, bus.busy}, 32'h0);
        expect_gnt("t3_fetch", 1'b1, 1'b0);
        exp_q.push_back({1'b0, 32'hAB});
        drive_edge();
        bus.if_req = 1'b0;
        wait_idle();

        // Continuous loads with fetch held: 4 loads, fetch, then load again.
        drive_edge();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h10;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h100;
        bus.d_size = SZ_WORD;
        for (int s = 0; s < 6; s++) begin
            logic want_if;
            want_if = (s == MAX_STREAK);
            @(negedge clk);
            expect_gnt($sformatf("t4_s%0d", s), want_if, ~want_if);
            if (want_if) begin
                chk("t4_if_size", {30'b0, bus.mem_size}, 32'h2);
                exp_q.push_back({1'b0, 32'h0050_0093});
            end else begin
                exp_q.push_back({1'b1, 32'hCAFE_F00D});
            end
            drive_edge();
            if (want_if) bus.if_addr = 32'h14;
            if (s == 5) begin
                bus.if_req = 1'b0;
                bus.d_req = 1'b0;
            end
            @(negedge clk);
            expect_gnt($sformatf("t4_w%0d", s), 1'b0, 1'b0);
        end
        wait_idle();

        // Reset one cycle into the wait discards the read.
        drive_edge();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h10;
        @(negedge clk);
        expect_gnt("t5", 1'b1, 1'b0);
        drive_edge();
        bus.if_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        expect_gnt("t5_rst", 1'b0, 1'b0);
        chk("t5_rst_mem_en", {31'b0, bus.mem_en}, 32'h0);
        drive_edge();
        rst = 1'b0;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h100;
        @(negedge clk);
        chk("t5_busy", {31'b0, bus.busy}, 32'h0);
        expect_gnt("t5_after", 1'b0, 1'b1);
        exp_q.push_back({1'b1, 32'hCAFE_F00D});
        drive_edge();
        bus.d_req = 1'b0;
        wait_idle();

        repeat (4) @(negedge clk);
        chk("sb_empty", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
